// File: rtl/hit_collector.sv
// Scans the InexRecur/state register files from address 0 and streams every
// successful SA interval [k,l], dropping back-to-back duplicates.
module hit_collector #(
    parameter int unsigned AW    = 12,
    parameter int unsigned DEPTH = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    output logic          re_ran_o,
    output logic [AW-1:0] r_addr_o,
    input  logic [31:0]   InexRecur_data_i,
    input  logic [17:0]   state_data_i,
    output logic          hit_valid_o,
    input  logic          hit_ready_i,
    output logic [7:0]    hit_k_o,
    output logic [7:0]    hit_l_o,
    output logic [7:0]    hit_z_o,
    output logic [AW:0]   hit_count_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int unsigned   CW        = AW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WT   = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_EMIT = 3'd4;
    localparam logic [2:0] S_NXT  = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_k;
    logic [7:0]    r_l;
    logic [7:0]    r_z;
    logic          r_alloc;
    logic          r_hit;
    logic [7:0]    r_prev_k;
    logic [7:0]    r_prev_l;
    logic          r_prev_vld;
    logic [CW-1:0] r_count;
    logic          r_re;
    logic          r_valid;
    logic          r_busy;
    logic          r_done;
    logic          w_emit_ok;
    logic          w_last;
    logic          w_unused_bits;

    // Fields of the read words that the collector never looks at
    assign w_unused_bits = ^{InexRecur_data_i[31:24], state_data_i[15:0]};

    assign w_emit_ok = r_hit && (r_k <= r_l) &&
                       !(r_prev_vld && (r_k == r_prev_k) && (r_l == r_prev_l));
    assign w_last    = (r_addr == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start_i) w_state_nxt = S_RD;
            S_RD:   w_state_nxt = S_WT;
            S_WT:   w_state_nxt = S_CHK;
            S_CHK: begin
                if (!r_alloc)       w_state_nxt = S_FIN;
                else if (w_emit_ok) w_state_nxt = S_EMIT;
                else                w_state_nxt = S_NXT;
            end
            S_EMIT: if (hit_ready_i) w_state_nxt = S_NXT;
            S_NXT:  w_state_nxt = w_last ? S_FIN : S_RD;
            S_FIN:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath; status outputs are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_k        <= '0;
            r_l        <= '0;
            r_z        <= '0;
            r_alloc    <= 1'b0;
            r_hit      <= 1'b0;
            r_prev_k   <= '0;
            r_prev_l   <= '0;
            r_prev_vld <= 1'b0;
            r_count    <= '0;
            r_re       <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_re    <= (w_state_nxt == S_RD);
            r_valid <= (w_state_nxt == S_EMIT);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= (w_state_nxt == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_addr     <= '0;
                        r_count    <= '0;
                        r_prev_vld <= 1'b0;
                    end
                end
                S_WT: begin
                    r_z     <= InexRecur_data_i[23:16];
                    r_k     <= InexRecur_data_i[15:8];
                    r_l     <= InexRecur_data_i[7:0];
                    r_alloc <= state_data_i[17];
                    r_hit   <= state_data_i[16];
                end
                S_EMIT: begin
                    if (hit_ready_i) begin
                        if (r_count != {CW{1'b1}}) r_count <= r_count + CW'(1);
                        r_prev_k   <= r_k;
                        r_prev_l   <= r_l;
                        r_prev_vld <= 1'b1;
                    end
                end
                S_NXT: begin
                    if (!w_last) r_addr <= r_addr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    assign re_ran_o    = r_re;
    assign r_addr_o    = r_addr;
    assign hit_valid_o = r_valid;
    assign hit_k_o     = r_k;
    assign hit_l_o     = r_l;
    assign hit_z_o     = r_z;
    assign hit_count_o = r_count;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

endmodule
